// File: rtl/reflet_mem_serializer_pkg.sv
// Shared definitions for the Reflet word-to-byte memory serializer:
// FSM state encoding, reduced-behaviour width codes and counter width.
package reflet_mem_serializer_pkg;

   // Serializer FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   // Reduced-behaviour width codes as produced by the upstream stage.
   localparam logic [1:0] RB_FULL = 2'b00;
   localparam logic [1:0] RB_32   = 2'b01;
   localparam logic [1:0] RB_16   = 2'b10;
   localparam logic [1:0] RB_8    = 2'b11;

   // Width of byte counts and byte indices; wordsize/8 never exceeds 16.
   localparam int CNT_W = 8;

endpackage

// File: rtl/reflet_mem_serializer_if.sv
// Bus bundle between the Reflet core memory port, the serializer and the
// 8-bit external memory.
//
// Handshake semantics:
//   core side   - cpu_req is sampled only while busy is low; acceptance is
//                 the rising edge where cpu_req=1 and the serializer is idle.
//                 cpu_ready pulses for exactly one cycle when the access has
//                 completed; busy covers acceptance up to and including the
//                 cpu_ready cycle.
//   memory side - mem_req=1 presents one byte transfer (mem_addr,
//                 mem_write_en, mem_data_out held stable). The transfer
//                 completes on the rising edge where mem_ack=1; mem_data_in
//                 is valid in that same cycle. mem_ack with mem_req=0 is
//                 ignored.
interface reflet_mem_serializer_if #(
   parameter int wordsize = 16
);
   logic                cpu_req;
   logic                cpu_write_en;
   logic [wordsize-1:0] cpu_addr;
   logic [wordsize-1:0] cpu_data_out;
   logic [1:0]          reduced_behavior_bits;
   logic [wordsize-1:0] cpu_data_in;
   logic                cpu_ready;
   logic                busy;

   logic                mem_req;
   logic                mem_write_en;
   logic [wordsize-1:0] mem_addr;
   logic [7:0]          mem_data_out;
   logic [7:0]          mem_data_in;
   logic                mem_ack;

   // Environment view: core plus external memory.
   modport master (
      output cpu_req, cpu_write_en, cpu_addr, cpu_data_out, reduced_behavior_bits,
      input  cpu_data_in, cpu_ready, busy,
      input  mem_req, mem_write_en, mem_addr, mem_data_out,
      output mem_data_in, mem_ack
   );

   // Serializer view.
   modport slave (
      input  cpu_req, cpu_write_en, cpu_addr, cpu_data_out, reduced_behavior_bits,
      output cpu_data_in, cpu_ready, busy,
      output mem_req, mem_write_en, mem_addr, mem_data_out,
      input  mem_data_in, mem_ack
   );
endinterface

// File: rtl/reflet_byte_count.sv
// Maps a reduced-behaviour code to the number of bytes an access moves,
// clamped to the bytes actually present in a core word.
module reflet_byte_count
   import reflet_mem_serializer_pkg::*;
#(
   parameter int wordsize = 16
) (
   input  logic [1:0]       bits_i,
   output logic [CNT_W-1:0] n_o
);

   localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(wordsize / 8);

   logic [CNT_W-1:0] raw_n;

   // Decode the width code, then clamp to the word size.
   always_comb begin
      raw_n = MAX_BYTES;
      case (bits_i)
         RB_32:   raw_n = CNT_W'(4);
         RB_16:   raw_n = CNT_W'(2);
         RB_8:    raw_n = CNT_W'(1);
         default: raw_n = MAX_BYTES;
      endcase
      n_o = (raw_n > MAX_BYTES) ? MAX_BYTES : raw_n;
   end

endmodule

// File: rtl/reflet_mem_serializer.sv
// Splits each core word access into little-endian byte transfers on an
// 8-bit request/acknowledge memory bus. Only the bytes required by the
// latched reduced-behaviour width are transferred.
module reflet_mem_serializer
   import reflet_mem_serializer_pkg::*;
#(
   parameter int wordsize = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   reflet_mem_serializer_if.slave  bus,
   output state_t                  dbg_state_o
);

   localparam int NBYTES = wordsize / 8;

   state_t              state_q, state_d;
   logic [wordsize-1:0] addr_q;
   logic [wordsize-1:0] wdata_q;
   logic                we_q;
   logic [CNT_W-1:0]    n_q;
   logic [CNT_W-1:0]    idx_q;
   logic [wordsize-1:0] rd_q, rd_d;
   logic [wordsize-1:0] rdata_q;

   logic [CNT_W-1:0]    n_w;
   logic                accept;
   logic                last_ack;
   logic [7:0]          wbyte;

   reflet_byte_count #(.wordsize(wordsize)) u_byte_count (
      .bits_i (bus.reduced_behavior_bits),
      .n_o    (n_w)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic plus the acceptance and final-byte strobes.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      last_ack = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cpu_req) begin
               state_d = ST_ACCESS;
               accept  = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (bus.mem_ack && (idx_q == n_q - CNT_W'(1))) begin
               state_d  = ST_DONE;
               last_ack = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Select the current write byte and merge the incoming read byte.
   always_comb begin
      wbyte = 8'h00;
      rd_d  = rd_q;
      for (int b = 0; b < NBYTES; b++) begin
         if (idx_q == CNT_W'(b)) begin
            wbyte          = wdata_q[b*8 +: 8];
            rd_d[b*8 +: 8] = bus.mem_data_in;
         end
      end
   end

   // Transaction latches, byte index counter and read assembly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         n_q     <= '0;
         idx_q   <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         addr_q  <= bus.cpu_addr;
         wdata_q <= bus.cpu_data_out;
         we_q    <= bus.cpu_write_en;
         n_q     <= n_w;
         idx_q   <= '0;
         if (!bus.cpu_write_en) rd_q <= '0;
      end else if ((state_q == ST_ACCESS) && bus.mem_ack) begin
         if (!we_q) rd_q <= rd_d;
         if (last_ack) begin
            // Publish the assembled word on entry to DONE; writes keep the
            // previous read result visible.
            if (!we_q) rdata_q <= rd_d;
         end else begin
            idx_q <= idx_q + CNT_W'(1);
         end
      end
   end

   // Outputs decoded from registered state only; zero outside ACCESS.
   assign bus.mem_req      = (state_q == ST_ACCESS);
   assign bus.mem_write_en = (state_q == ST_ACCESS) && we_q;
   assign bus.mem_addr     = (state_q == ST_ACCESS) ? (addr_q + wordsize'(idx_q)) : '0;
   assign bus.mem_data_out = (state_q == ST_ACCESS) ? wbyte : 8'h00;
   assign bus.cpu_ready    = (state_q == ST_DONE);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.cpu_data_in  = rdata_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_reflet_mem_serializer.sv
// Bench for reflet_mem_serializer at wordsize 16: directed scenarios plus
// random word accesses against a byte-array memory reference.
module tb_reflet_mem_serializer;
  import reflet_mem_serializer_pkg::*;

  localparam int WS = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reflet_mem_serializer_if #(.wordsize(WS)) bus ();
  state_t dbg_state;

  reflet_mem_serializer #(.wordsize(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Memory seen by the DUT and reference memory updated by the model.
  logic [7:0] mem_dut [65536];
  logic [7:0] mem_ref [65536];

  // Scoreboard: expected byte addresses and write bytes, in order.
  logic [WS-1:0] exp_q [$];
  logic [7:0]    exp_byte_q [$];
  bit            cur_we;
  int            wait_cfg;
  int            wcnt;
  logic [WS-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_mem_req", 32'd1, 32'd0);
        bus.mem_ack = 1'b0;
      end else begin
        check_eq("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0]));
        check_eq("mem_we", 32'(bus.mem_write_en), 32'(cur_we));
        if (cur_we) check_eq("mem_wdata", 32'(bus.mem_data_out), 32'(exp_byte_q[0]));
        if (wcnt < wait_cfg) begin
          bus.mem_ack = 1'b0;
          bus.mem_data_in = 8'($urandom);
          wcnt++;
        end else begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          if (cur_we) mem_dut[bus.mem_addr] = bus.mem_data_out;
          else bus.mem_data_in = mem_dut[bus.mem_addr];
          void'(exp_q.pop_front());
          void'(exp_byte_q.pop_front());
        end
      end
    end else begin
      // Stray acks while not in ACCESS must be ignored.
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.mem_data_in = 8'($urandom);
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic run_txn(input bit we, input logic [WS-1:0] addr, input logic [WS-1:0] data,
                         input logic [1:0] bits, input int waits, input bit pulse);
    int n;
    int exp_cycle;
    int cycle;
    bit seen;
    logic [WS-1:0] exp_rd;
    logic [WS-1:0] a;
    case (bits)
      2'b01:   n = 4;
      2'b10:   n = 2;
      2'b11:   n = 1;
      default: n = WS / 8;
    endcase
    if (n > WS / 8) n = WS / 8;
    exp_rd = '0;
    cur_we = we;
    wait_cfg = waits;
    wcnt = 0;
    for (int k = 0; k < n; k++) begin
      a = addr + WS'(k);
      exp_q.push_back(a);
      exp_byte_q.push_back(data[8*k +: 8]);
      if (we) mem_ref[a] = data[8*k +: 8];
      else exp_rd[8*k +: 8] = mem_ref[a];
    end
    if (!we) last_rd = exp_rd;
    exp_cycle = n * (waits + 1) + 1;

    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_write_en = we;
    bus.cpu_addr = addr;
    bus.cpu_data_out = data;
    bus.reduced_behavior_bits = bits;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_write_en = 1'($urandom_range(0, 1));
    bus.cpu_addr = WS'($urandom);
    bus.cpu_data_out = WS'($urandom);
    bus.reduced_behavior_bits = 2'($urandom_range(0, 3));
    cycle = 1;
    seen = 0;
    while (!seen && cycle <= 200) begin
      bus.cpu_req = (pulse && cycle == 2);
      if (bus.cpu_ready === 1'b1) begin
        seen = 1;
        check_eq("ready_cycle", 32'(cycle), 32'(exp_cycle));
        check_eq("cpu_data_in", 32'(bus.cpu_data_in), 32'(last_rd));
        check_eq("busy_at_ready", 32'(bus.busy), 32'd1);
      end else begin
        check_eq("busy_active", 32'(bus.busy), 32'd1);
        @(negedge clk);
        cycle++;
      end
    end
    if (!seen) check_eq("ready_timeout", 32'd0, 32'd1);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check_eq("busy_after", 32'(bus.busy), 32'd0);
    check_eq("ready_pulse", 32'(bus.cpu_ready), 32'd0);
    check_eq("all_bytes_done", 32'(exp_q.size()), 32'd0);
    check_eq("data_hold", 32'(bus.cpu_data_in), 32'(last_rd));
    for (int k = -1; k <= 4; k++) begin
      a = addr + WS'(k);
      check_eq("mem_byte", 32'(mem_dut[a]), 32'(mem_ref[a]));
    end
    exp_q.delete();
    exp_byte_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(bus.mem_write_en), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(bus.mem_data_out), 32'd0);
    check_eq({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_cpu_data_in"}, 32'(bus.cpu_data_in), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog run did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_write_en = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data_out = '0;
    bus.reduced_behavior_bits = 2'b00;
    last_rd = '0;
    wait_cfg = 0;
    wcnt = 0;
    cur_we = 0;
    for (int i = 0; i < 65536; i++) begin
      mem_dut[i] = 8'($urandom);
      mem_ref[i] = mem_dut[i];
    end
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full-word read.
    mem_dut[16'h0010] = 8'h34; mem_ref[16'h0010] = 8'h34;
    mem_dut[16'h0011] = 8'h12; mem_ref[16'h0011] = 8'h12;
    run_txn(1'b0, 16'h0010, 16'h0000, RB_FULL, 0, 1'b0);
    check_eq("full_read_value", 32'(bus.cpu_data_in), 32'h1234);

    // Reduced write: single byte 0xDD.
    run_txn(1'b1, 16'h0100, 16'hCCDD, RB_8, 0, 1'b0);
    check_eq("reduced_write_byte", 32'(mem_dut[16'h0100]), 32'hDD);

    // Wait states: three wait cycles per byte.
    run_txn(1'b0, 16'h0200, 16'h0000, RB_FULL, 3, 1'b0);

    // Address wrap with clamped 32-bit code.
    run_txn(1'b0, 16'hFFFF, 16'h0000, RB_32, 0, 1'b0);
    run_txn(1'b1, 16'hFFFF, 16'hBEEF, RB_32, 1, 1'b0);

    // Request pulse during ACCESS is ignored.
    run_txn(1'b1, 16'h0300, 16'h5A6B, RB_16, 1, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("no_second_txn", 32'(bus.mem_req), 32'd0);

    // Asynchronous reset in the middle of a read.
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0401);
    exp_byte_q.push_back(8'h00);
    exp_byte_q.push_back(8'h00);
    cur_we = 0;
    wait_cfg = 2;
    wcnt = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_write_en = 1'b0;
    bus.cpu_addr = 16'h0400;
    bus.reduced_behavior_bits = RB_FULL;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check_eq("pre_reset_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_byte_q.delete();
    wcnt = 0;
    last_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("post_reset_no_ready", 32'(bus.cpu_ready), 32'd0);
    end
    mem_dut[16'h2000] = 8'h04; mem_ref[16'h2000] = 8'h04;
    mem_dut[16'h2001] = 8'h03; mem_ref[16'h2001] = 8'h03;
    run_txn(1'b0, 16'h2000, 16'h0000, RB_FULL, 0, 1'b0);
    check_eq("post_reset_read", 32'(bus.cpu_data_in), 32'h0304);

    // Random accesses.
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), WS'($urandom), WS'($urandom),
              2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_mem_serializer.md
# reflet_mem_serializer

Sequential bridge between the Reflet core's word-wide memory port and an 8-bit external memory bus. It sits directly downstream of the reduced-behaviour stage, on the core side of RAM. It splits each word read or write into little-endian byte transfers with a request/acknowledge handshake. It transfers only the bytes the active reduced-behaviour width requires.

## Interface
- `wordsize`, 16, core word width in bits; multiple of 8, range 8..128.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `cpu_req`  in  1  access request; sampled only in IDLE.
- `cpu_write_en`  in  1  1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr`  in  wordsize  byte address of the access (byte 0 of the word).
- `cpu_data_out`  in  wordsize  write data; captured on request acceptance.
- `reduced_behavior_bits`  in  2  00 full word, 01 32-bit, 10 16-bit, 11 8-bit; captured on acceptance.
- `cpu_data_in`  out  wordsize  read result; zero-extended above transferred bytes.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from acceptance until the cycle after `cpu_ready`.
- `mem_req`  out  1  byte transfer request.
- `mem_write_en`  out  1  direction of the current byte transfer.
- `mem_addr`  out  wordsize  byte address of the current transfer.
- `mem_data_out`  out  8  write byte.
- `mem_data_in`  in  8  read byte; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  completes the current byte transfer.

## Operation
- States: IDLE, ACCESS, DONE.
- Byte count n = 4 for bits 01, 2 for bits 10, 1 for bits 11, wordsize/8 for bits 00. n is then clamped to at most wordsize/8.
- **IDLE → ACCESS** when `cpu_req` = 1. On this edge the block latches the address, write data, direction and n, and clears byte index i to 0. For reads it also clears the read shift register.
- **In ACCESS:**
  - `mem_req` = 1.
  - `mem_addr` = latched address + i, modulo 2^wordsize. An address of all ones wraps to 0.
  - `mem_data_out` = byte i of the latched write data.
  - `mem_write_en` = latched direction.
- **On each edge with `mem_ack` = 1:**
  - Reads store `mem_data_in` into byte i.
  - If i = n-1, go to DONE; otherwise i increments.
- `mem_ack` high outside ACCESS is ignored.
- **DONE:**
  - `cpu_ready` = 1 for exactly one cycle.
  - For reads, `cpu_data_in` updates with the assembled value on entry to DONE. It then holds until the next completed read; writes leave it unchanged.
  - After one cycle, return to IDLE.
- Writes drive only n bytes. Memory bytes above n are never touched.
- `cpu_req` while `busy` is ignored; no queuing.
- A missing `mem_ack` stalls indefinitely in ACCESS. There is no timeout.
- Reset mid-transfer:
  - The FSM returns to IDLE immediately and all outputs go to reset values.
  - The partial write is not rolled back and no `cpu_ready` is produced.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_write_en`, `cpu_ready`, `busy` = 0; `mem_addr`, `mem_data_out`, `cpu_data_in` = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `mem_ack` or `mem_data_in` to any output.
- With `cpu_req` accepted at edge 0 and `mem_ack` held at 1:
  - ACCESS occupies cycles 1..n.
  - `cpu_ready` is high in cycle n+1.
  - The next request can be accepted at edge n+2.
- Each wait cycle (`mem_ack` = 0) extends ACCESS by one cycle. Address and data stay stable while `mem_req` = 1 and `mem_ack` = 0.
- Between consecutive bytes `mem_req` stays high; `mem_addr` advances on the edge that sampled `mem_ack`.

## Structure
- Shared package or header holds:
  - state encodings (IDLE/ACCESS/DONE);
  - the reduced-behaviour code constants (2'b00..2'b11).
- One natural sub-module, `reflet_byte_count`: combinational mapping of `reduced_behavior_bits` and `wordsize` to n. It is reusable by the reduced-behaviour stage for its pop offset.
- The top level holds the FSM, byte index counter, write shift source and read assembly register.

## Test plan
- **Full-word read:** wordsize 16, bits 00, addr 0x0010, memory bytes 0x34 then 0x12, ack always 1. Expect `mem_addr` 0x0010 then 0x0011, `cpu_data_in` = 0x1234, `cpu_ready` in cycle 3.
- **Reduced write:** wordsize 32, bits 11, addr 0x100, data 0xAABBCCDD. Expect exactly one transfer, addr 0x100, byte 0xDD, `mem_write_en` = 1; no further `mem_req`.
- **Wait states:** wordsize 16 read with `mem_ack` low 3 cycles per byte. Expect addr/data stable during waits and `cpu_ready` in cycle 9 after acceptance.
- **Address wrap and clamp:** wordsize 16, bits 01 (n clamped to 2), addr 0xFFFF. Expect addresses 0xFFFF then 0x0000.
- **Busy and ignored request:** pulse `cpu_req` during ACCESS. Expect no second transaction and `busy` = 1 until the cycle after `cpu_ready`.
- **Async reset mid-operation:** assert `reset` between edges during ACCESS of a 4-byte read. Expect all outputs 0 immediately, no `cpu_ready`, and a clean subsequent read of 0x01020304.
